// File: rtl/trisc_ctrl_fsm.sv
// TRISC control FSM: fetch/decode/execute sequencing with memory wait states, flag branches, halt and illegal-opcode detection.
// Optional single-step mode via TRISC_CTRL_SINGLE_STEP_EN (adds step input and PAUSE state).
module trisc_ctrl_fsm #(
  parameter int OPCODE_W = 4,
  parameter int MEM_WAIT = 2,
  parameter int WAIT_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                neg,
`ifdef TRISC_CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic [14:0]         ctrl,
  output logic                halted,
  output logic                instr_done,
  output logic                illegal,
  output logic [4:0]          state_dbg
);

  typedef enum logic [4:0] {
    IDLE = 5'd0, FETCH_ADDR = 5'd1, FETCH_RD = 5'd2, DECODE = 5'd3, DISPATCH = 5'd4,
    OP_ADDR = 5'd5, OP_RD = 5'd6, LD_WB = 5'd7, ALU_WB = 5'd8, ST_DATA = 5'd9,
    ST_WR = 5'd10, EX_INC = 5'd11, EX_CLR = 5'd12, EX_JMP = 5'd13, HALT = 5'd14
`ifdef TRISC_CTRL_SINGLE_STEP_EN
    , PAUSE = 5'd15
`endif
  } state_t;

`ifdef TRISC_CTRL_SINGLE_STEP_EN
  localparam state_t RESUME = PAUSE;
`else
  localparam state_t RESUME = FETCH_ADDR;
`endif
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

  state_t            state, nxt;
  logic [WAIT_W-1:0] cnt, nxt_cnt;
  logic [3:0]        op_q, op_lo;
  logic              op_ill, wait_end, disp_done;
  logic [14:0]       ctrl_q;
  logic              halted_q, done_q;

  function automatic logic [14:0] ctrl_of(input state_t s, input logic [3:0] op);
    logic [14:0] c;
    c = '0;
    case (s)
      FETCH_ADDR:              c[0] = 1'b1;
      FETCH_RD, OP_RD:         c[3] = 1'b1;
      DECODE:                  begin c[4] = 1'b1; c[2] = 1'b1; end
      OP_ADDR:                 c[5] = 1'b1;
      LD_WB:                   c[8] = 1'b1;
      ST_DATA:                 c[9] = 1'b1;
      ST_WR:                   c[10] = 1'b1;
      EX_INC:                  c[6] = 1'b1;
      EX_CLR:                  c[7] = 1'b1;
      EX_JMP:                  c[1] = 1'b1;
      ALU_WB: begin
        c[14] = 1'b1;
        c[11] = (op == 4'd2);
        c[12] = (op == 4'd3);
        c[13] = (op == 4'd4);
      end
      default:                 c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_lo     = opcode[3:0];
    op_ill    = ((opcode >> 4) != '0) || (op_lo inside {[4'd10:4'd14]});
    wait_end  = (cnt == WAIT_LAST);
    disp_done = (state == DISPATCH) &&
                (op_ill || (op_lo == 4'd8 && !zero) || (op_lo == 4'd9 && !neg));
    nxt = state;
    case (state)
      IDLE:       if (run) nxt = FETCH_ADDR;
      FETCH_ADDR: nxt = FETCH_RD;
      FETCH_RD:   if (wait_end) nxt = DECODE;
      DECODE:     nxt = DISPATCH;
      DISPATCH: begin
        if (op_ill) nxt = RESUME;
        else case (op_lo)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4: nxt = OP_ADDR;
          4'd5:    nxt = EX_INC;
          4'd6:    nxt = EX_CLR;
          4'd7:    nxt = EX_JMP;
          4'd8:    nxt = zero ? EX_JMP : RESUME;
          4'd9:    nxt = neg ? EX_JMP : RESUME;
          4'd15:   nxt = HALT;
          default: nxt = RESUME;
        endcase
      end
      OP_ADDR:    nxt = (op_q == 4'd1) ? ST_DATA : OP_RD;
      OP_RD:      if (wait_end) nxt = (op_q == 4'd0) ? LD_WB : ALU_WB;
      ST_DATA:    nxt = ST_WR;
      ST_WR:      if (wait_end) nxt = RESUME;
      LD_WB, ALU_WB, EX_INC, EX_CLR, EX_JMP: nxt = RESUME;
      HALT:       nxt = HALT;
`ifdef TRISC_CTRL_SINGLE_STEP_EN
      PAUSE:      if (step) nxt = FETCH_ADDR;
`endif
      default:    nxt = IDLE;
    endcase
    // Counter restarts on every state change so each wait state sees 0..MEM_WAIT.
    nxt_cnt = (nxt == state) ? cnt + 1'b1 : '0;
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      ctrl_q   <= '0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= nxt_cnt;
      if (state == DISPATCH) op_q <= op_lo;
      ctrl_q   <= ctrl_of(nxt, (state == DISPATCH) ? op_lo : op_q);
      halted_q <= (nxt == HALT);
      done_q   <= (nxt inside {EX_INC, EX_CLR, EX_JMP, LD_WB, ALU_WB}) ||
                  (nxt == ST_WR && nxt_cnt == WAIT_LAST) ||
                  (nxt == HALT && state != HALT);
    end
  end

  // DISPATCH completion depends on the live opcode/flags, so it bypasses the output registers.
  assign ctrl       = ctrl_q;
  assign halted     = halted_q;
  assign instr_done = done_q | disp_done;
  assign illegal    = (state == DISPATCH) && op_ill;
  assign state_dbg  = state;

endmodule

// File: tb/tb_trisc_ctrl_fsm.sv
// Directed bench for trisc_ctrl_fsm: MEM_WAIT=2 main instance plus a MEM_WAIT=0 instance.
module tb_trisc_ctrl_fsm;
  localparam logic [4:0] S_IDLE = 5'd0, S_FA = 5'd1, S_OPRD = 5'd6, S_HALT = 5'd14;

  logic clock = 1'b0;
  logic reset, run, zero, neg, reset1, run1, step;
  logic [3:0] opcode;
  logic [14:0] ctrl, ctrl1;
  logic halted, instr_done, illegal, halted1, instr_done1, illegal1;
  logic [4:0] state_dbg, state_dbg1;

  int npass = 0, nfail = 0, ntot = 0;
  logic [14:0] dec_ctrl;

  always #5 clock = ~clock;

  trisc_ctrl_fsm #(.OPCODE_W(4), .MEM_WAIT(2), .WAIT_W(4)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .zero(zero), .neg(neg),
`ifdef TRISC_CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .ctrl(ctrl), .halted(halted), .instr_done(instr_done), .illegal(illegal), .state_dbg(state_dbg));

  trisc_ctrl_fsm #(.OPCODE_W(4), .MEM_WAIT(0), .WAIT_W(4)) dut0 (
    .clock(clock), .reset(reset1), .run(run1), .opcode(opcode), .zero(zero), .neg(neg),
`ifdef TRISC_CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .ctrl(ctrl1), .halted(halted1), .instr_done(instr_done1), .illegal(illegal1), .state_dbg(state_dbg1));

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts sampled in FETCH_ADDR; walks to the instr_done cycle and checks its shape.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic z, input logic n,
                           input int exp_cyc, input logic [14:0] exp_ctrl, input int exp_rd,
                           input int exp_wr, input logic exp_ill);
    int c, rd, wr;
    logic ill;
    logic [14:0] dctrl;
    opcode = op; zero = z; neg = n;
    rd = 0; wr = 0; ill = 1'b0; dctrl = '0;
    chk($sformatf("%s start", tag), state_dbg, S_FA);
    for (c = 1; c < 40; c++) begin
      rd += int'(ctrl[3]);
      wr += int'(ctrl[10]);
      ill |= illegal;
      if (c == 5) dec_ctrl = ctrl;
      if (instr_done) begin
        dctrl = ctrl;
        break;
      end
      cyc();
    end
    chk($sformatf("%s cycles", tag), c, exp_cyc);
    chk($sformatf("%s done_ctrl", tag), dctrl, exp_ctrl);
    chk($sformatf("%s mem_read", tag), rd, exp_rd);
    chk($sformatf("%s mem_write", tag), wr, exp_wr);
    chk($sformatf("%s illegal", tag), ill, exp_ill);
    if (op != 4'd15) begin
      cyc();
      chk($sformatf("%s next", tag), state_dbg, S_FA);
    end
  endtask

  initial begin
    int bad, c;
    reset = 1'b1; run = 1'b0; opcode = 4'd5; zero = 1'b0; neg = 1'b0;
    reset1 = 1'b1; run1 = 1'b0; step = 1'b0;
    cyc(); cyc();
    chk("reset state", state_dbg, S_IDLE);
    chk("reset ctrl", ctrl, 15'h0000);
    chk("reset halted", halted, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle state", state_dbg, S_IDLE);
    end
    chk("idle ctrl", ctrl, 15'h0000);
    chk("idle done", instr_done, 1'b0);
    run = 1'b1;
    cyc();
    chk("run state", state_dbg, S_FA);
    chk("run ctrl", ctrl, 15'h0001);
    run = 1'b0;

    run_instr("INC", 4'd5, 1'b0, 1'b0, 7, 15'h0040, 3, 0, 1'b0);
    chk("decode ctrl", dec_ctrl, 15'h0014);
    run_instr("CLR", 4'd6, 1'b0, 1'b0, 7, 15'h0080, 3, 0, 1'b0);
    run_instr("JMP", 4'd7, 1'b0, 1'b0, 7, 15'h0002, 3, 0, 1'b0);
    run_instr("LDA", 4'd0, 1'b0, 1'b0, 11, 15'h0100, 6, 0, 1'b0);
    run_instr("STA", 4'd1, 1'b0, 1'b0, 11, 15'h0400, 3, 3, 1'b0);
    run_instr("ADD", 4'd2, 1'b0, 1'b0, 11, 15'h4800, 6, 0, 1'b0);
    run_instr("SUB", 4'd3, 1'b0, 1'b0, 11, 15'h5000, 6, 0, 1'b0);
    run_instr("XOR", 4'd4, 1'b0, 1'b0, 11, 15'h6000, 6, 0, 1'b0);
    run_instr("JPZ nt", 4'd8, 1'b0, 1'b1, 6, 15'h0000, 3, 0, 1'b0);
    run_instr("JPZ t", 4'd8, 1'b1, 1'b0, 7, 15'h0002, 3, 0, 1'b0);
    run_instr("JPN nt", 4'd9, 1'b1, 1'b0, 6, 15'h0000, 3, 0, 1'b0);
    run_instr("JPN t", 4'd9, 1'b0, 1'b1, 7, 15'h0002, 3, 0, 1'b0);
    run_instr("ILL12", 4'd12, 1'b0, 1'b0, 6, 15'h0000, 3, 0, 1'b1);

    // Reset in the second OP_RD cycle of an LDA.
    opcode = 4'd0; zero = 1'b0; neg = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    chk("midrst pre", state_dbg, S_OPRD);
    chk("midrst pre ctrl", ctrl, 15'h0008);
    reset = 1'b1;
    cyc();
    chk("midrst state", state_dbg, S_IDLE);
    chk("midrst ctrl", ctrl, 15'h0000);
    chk("midrst done", instr_done, 1'b0);
    reset = 1'b0; run = 1'b1;
    cyc();
    run = 1'b0;

    run_instr("HLT", 4'd15, 1'b0, 1'b0, 7, 15'h0000, 3, 0, 1'b0);
    chk("halt state", state_dbg, S_HALT);
    chk("halt flag", halted, 1'b1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      run = (i % 2 == 0);
      cyc();
      if (halted !== 1'b1 || state_dbg !== S_HALT || instr_done !== 1'b0 || ctrl !== 15'h0)
        bad++;
    end
    chk("halt hold", bad, 0);
    run = 1'b0; reset = 1'b1;
    cyc();
    chk("halt reset state", state_dbg, S_IDLE);
    chk("halt reset flag", halted, 1'b0);
    reset = 1'b0;

    // MEM_WAIT=0 instance: INC in 5 cycles.
    opcode = 4'd5;
    reset1 = 1'b0; run1 = 1'b1;
    cyc();
    run1 = 1'b0;
    chk("mw0 start", state_dbg1, S_FA);
    for (c = 1; c < 20; c++) begin
      if (instr_done1) break;
      cyc();
    end
    chk("mw0 cycles", c, 5);
    chk("mw0 ctrl", ctrl1, 15'h0040);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
